// File: rtl/floor_call_scheduler.sv
// Floor call scheduler: latches call buttons, runs a collective up/down sweep to pick
// the one-hot target floor for the elevator controller, and times the door dwell.
module floor_call_scheduler #(
  parameter int NUM_FLOORS   = 4,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [NUM_FLOORS-1:0] present_floor,
  output logic [NUM_FLOORS-1:0] requested_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open,
  output logic                  busy,
  output logic                  fault
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0]         DWELL_LOAD = CW'(DWELL_CYCLES - 1);
  localparam logic [NUM_FLOORS-1:0] FLOOR0     = NUM_FLOORS'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_UP    = 2'd1,
    S_DOWN  = 2'd2,
    S_DWELL = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  dir_q, dir_d;
  logic [NUM_FLOORS-1:0] pend_q, pend_d;
  logic [NUM_FLOORS-1:0] req_q, req_d;
  logic                  door_q, door_d;
  logic                  busy_q, busy_d;
  logic                  fault_q, fault_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_FLOORS-1:0] btn_q;

  logic [NUM_FLOORS-1:0] rise_s, above_s, below_s, pend_above_s, pend_below_s, clr_s;
  logic                  onehot_s, here_pend_s, here_rise_s;

  function automatic logic [NUM_FLOORS-1:0] lowest_bit(input logic [NUM_FLOORS-1:0] v);
    return v & (~v + NUM_FLOORS'(1));
  endfunction

  function automatic logic [NUM_FLOORS-1:0] highest_bit(input logic [NUM_FLOORS-1:0] v);
    logic [NUM_FLOORS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      r = v[i] ? (NUM_FLOORS'(1) << i) : r;
    end
    return r;
  endfunction

  // Floors strictly above the one-hot position p.
  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [NUM_FLOORS-1:0] p);
    logic                  seen;
    logic [NUM_FLOORS-1:0] m;
    seen = 1'b0;
    m    = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      m[i] = seen;
      seen = seen | p[i];
    end
    return m;
  endfunction

  always_comb begin
    rise_s       = call_btn & ~btn_q;
    onehot_s     = $onehot(present_floor);
    above_s      = above_mask(present_floor);
    below_s      = ~(above_s | present_floor);
    pend_above_s = pend_q & above_s;
    pend_below_s = pend_q & below_s;
    here_pend_s  = |(pend_q & present_floor);
    here_rise_s  = |(rise_s & present_floor);
  end

  // Sweep FSM: next state, target floor, dwell timer and which pending bit to drop.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    req_d   = present_floor;
    door_d  = 1'b0;
    cnt_d   = cnt_q;
    clr_s   = '0;
    if (!onehot_s) begin
      state_d = S_IDLE;
      req_d   = FLOOR0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A press at the present floor opens the door straight away, never latched.
          if (here_pend_s || here_rise_s) begin
            state_d = S_DWELL;
            door_d  = 1'b1;
            cnt_d   = DWELL_LOAD;
            clr_s   = present_floor;
          end else if (|pend_above_s) begin
            state_d = S_UP;
            dir_d   = 1'b1;
            req_d   = lowest_bit(pend_above_s);
          end else if (|pend_below_s) begin
            state_d = S_DOWN;
            dir_d   = 1'b0;
            req_d   = highest_bit(pend_below_s);
          end else begin
            state_d = S_IDLE;
          end
        end
        S_UP: begin
          if ((present_floor == req_q) && here_pend_s) begin
            state_d = S_DWELL;
            door_d  = 1'b1;
            cnt_d   = DWELL_LOAD;
            clr_s   = present_floor;
          end else if (|pend_above_s) begin
            req_d = lowest_bit(pend_above_s);
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DOWN: begin
          if ((present_floor == req_q) && here_pend_s) begin
            state_d = S_DWELL;
            door_d  = 1'b1;
            cnt_d   = DWELL_LOAD;
            clr_s   = present_floor;
          end else if (|pend_below_s) begin
            req_d = highest_bit(pend_below_s);
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DWELL: begin
          clr_s  = present_floor;
          door_d = 1'b1;
          if (here_rise_s) begin
            cnt_d = DWELL_LOAD;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            door_d = 1'b0;
            if (dir_q && (|pend_above_s)) begin
              state_d = S_UP;
              req_d   = lowest_bit(pend_above_s);
            end else if (|pend_below_s) begin
              state_d = S_DOWN;
              dir_d   = 1'b0;
              req_d   = highest_bit(pend_below_s);
            end else if (|pend_above_s) begin
              state_d = S_UP;
              dir_d   = 1'b1;
              req_d   = lowest_bit(pend_above_s);
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          req_d   = FLOOR0;
        end
      endcase
    end
  end

  // Clearing a bit wins over a new call for the same floor on the same edge.
  always_comb begin
    pend_d  = (pend_q | rise_s) & ~clr_s;
    busy_d  = (state_d != S_IDLE);
    fault_d = !onehot_s;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b1;
      pend_q  <= '0;
      req_q   <= FLOOR0;
      door_q  <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
      btn_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
      door_q  <= door_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      btn_q   <= call_btn;
    end
  end

  assign requested_floor = req_q;
  assign pending         = pend_q;
  assign door_open       = door_q;
  assign busy            = busy_q;
  assign fault           = fault_q;

endmodule

// File: tb/tb_floor_call_scheduler.sv
// Self-checking bench for floor_call_scheduler: directed scenarios plus random calls,
// checked against a floor-index reference model driven by a 3-cycles-per-floor car.
module tb_floor_call_scheduler;

  localparam int N = 4;
  localparam int D = 4;
  localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_DWELL = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] call_btn;
  logic [N-1:0] present_floor;
  logic [N-1:0] requested_floor;
  logic [N-1:0] pending;
  logic         door_open;
  logic         busy;
  logic         fault;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int           m_mode;
  bit           m_dir;
  logic [N-1:0] m_pend, m_req, m_prev;
  bit           m_door, m_fault;
  int           m_elapsed;

  // Behavioural car
  int pos;
  int mtimer;
  bit fault_inj;

  floor_call_scheduler #(.NUM_FLOORS(N), .DWELL_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .call_btn(call_btn), .present_floor(present_floor),
    .requested_floor(requested_floor), .pending(pending), .door_open(door_open),
    .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [2*N+2:0] m_vec();
    return {m_req, m_pend, m_door, (m_mode != M_IDLE), m_fault};
  endfunction

  function automatic logic [2*N+2:0] d_vec();
    return {requested_floor, pending, door_open, busy, fault};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_dir = 1'b1; m_pend = '0; m_req = N'(1); m_prev = '0;
    m_door = 1'b0; m_fault = 1'b0; m_elapsed = 0; mtimer = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] rises, old, np;
    int cur, up_t, dn_t, ones;
    bit enter;
    rises = call_btn & ~m_prev;
    m_prev = call_btn;
    old = m_pend;
    ones = 0; cur = 0;
    for (int f = 0; f < N; f++) if (present_floor[f]) begin ones++; cur = f; end
    if (ones != 1) begin
      m_fault = 1'b1; m_mode = M_IDLE; m_req = N'(1); m_door = 1'b0; m_pend = old | rises;
      return;
    end
    m_fault = 1'b0;
    up_t = -1; dn_t = -1;
    for (int f = cur + 1; f < N; f++) if (old[f] && up_t < 0) up_t = f;
    for (int f = cur - 1; f >= 0; f--) if (old[f] && dn_t < 0) dn_t = f;
    np = old | rises;
    if (m_mode == M_DWELL) np[cur] = 1'b0;
    enter = 1'b0;
    m_door = 1'b0;
    case (m_mode)
      M_IDLE: begin
        m_req = N'(1) << cur;
        if (old[cur] || rises[cur]) enter = 1'b1;
        else if (up_t >= 0) begin m_mode = M_UP; m_dir = 1'b1; m_req = N'(1) << up_t; end
        else if (dn_t >= 0) begin m_mode = M_DOWN; m_dir = 1'b0; m_req = N'(1) << dn_t; end
      end
      M_UP: begin
        if (m_req == (N'(1) << cur) && old[cur]) enter = 1'b1;
        else if (up_t >= 0) m_req = N'(1) << up_t;
        else begin m_mode = M_IDLE; m_req = N'(1) << cur; end
      end
      M_DOWN: begin
        if (m_req == (N'(1) << cur) && old[cur]) enter = 1'b1;
        else if (dn_t >= 0) m_req = N'(1) << dn_t;
        else begin m_mode = M_IDLE; m_req = N'(1) << cur; end
      end
      default: begin
        m_req = N'(1) << cur;
        m_door = 1'b1;
        if (rises[cur]) m_elapsed = 1;
        else if (m_elapsed < D) m_elapsed++;
        else begin
          m_door = 1'b0;
          if (m_dir && up_t >= 0) begin m_mode = M_UP; m_req = N'(1) << up_t; end
          else if (dn_t >= 0) begin m_mode = M_DOWN; m_dir = 1'b0; m_req = N'(1) << dn_t; end
          else if (up_t >= 0) begin m_mode = M_UP; m_dir = 1'b1; m_req = N'(1) << up_t; end
          else m_mode = M_IDLE;
        end
      end
    endcase
    if (enter) begin
      m_mode = M_DWELL; m_door = 1'b1; m_elapsed = 1; np[cur] = 1'b0; m_req = N'(1) << cur;
    end
    m_pend = np;
  endtask

  // One clock: model sees the same pre-edge inputs as the DUT, then the car moves.
  task automatic tick();
    int tgt;
    model_step();
    @(posedge clk);
    #1;
    if (fault_inj) begin
      mtimer = 0;
    end else begin
      tgt = pos;
      for (int f = 0; f < N; f++) if (m_req[f]) tgt = f;
      if (tgt != pos) begin
        mtimer++;
        if (mtimer == 3) begin
          pos = (tgt > pos) ? pos + 1 : pos - 1;
          mtimer = 0;
        end
      end else mtimer = 0;
      present_floor = N'(1) << pos;
    end
  endtask

  task automatic travel_to(input int f);
    call_btn = N'(1) << f;
    tick();
    call_btn = '0;
    n_vec++;
    if (d_vec() !== m_vec()) begin
      n_err++; $display("FAIL travel_press: dut=%b model=%b", d_vec(), m_vec());
    end
    for (int c = 0; c < 300 && !(m_mode == M_IDLE && pos == f); c++) begin
      tick();
      n_vec++;
      if (d_vec() !== m_vec()) begin
        n_err++; $display("FAIL travel_run: dut=%b model=%b", d_vec(), m_vec());
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; call_btn = '0; pos = 0; fault_inj = 1'b0; present_floor = N'(1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (d_vec() !== 11'b0001_0000_000) begin
      n_err++; $display("FAIL reset_values: got %b want %b", d_vec(), 11'b0001_0000_000);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_call();
    int door_cnt;
    call_btn = 4'b0100;
    tick();
    call_btn = '0;
    n_vec++;
    if (pending !== 4'b0100) begin
      n_err++; $display("FAIL single_latch: got %b want %b", pending, 4'b0100);
    end
    tick();
    n_vec++;
    if ({requested_floor, busy} !== {4'b0100, 1'b1}) begin
      n_err++; $display("FAIL single_dispatch: got %b want %b", {requested_floor, busy}, 5'b01001);
    end
    for (int c = 0; c < 100 && !m_door; c++) begin
      tick();
      n_vec++;
      if (d_vec() !== m_vec()) begin
        n_err++; $display("FAIL single_move: dut=%b model=%b", d_vec(), m_vec());
      end
    end
    door_cnt = 0;
    for (int c = 0; c < 20 && door_open; c++) begin
      door_cnt++;
      tick();
    end
    n_vec++;
    if ({door_cnt, pending, busy, present_floor} !== {32'd4, 4'b0000, 1'b0, 4'b0100}) begin
      n_err++; $display("FAIL single_dwell: door=%0d pend=%b busy=%b at=%b want 4 0000 0 0100",
                        door_cnt, pending, busy, present_floor);
    end
  endtask

  task automatic test_reset_mid_dwell();
    call_btn = present_floor | 4'b0010;
    tick();
    call_btn = '0;
    tick();
    n_vec++;
    if ({door_open, pending} !== {1'b1, 4'b0010}) begin
      n_err++; $display("FAIL rstdwell_pre: got %b want %b", {door_open, pending}, 5'b10010);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (d_vec() !== 11'b0001_0000_000) begin
      n_err++; $display("FAIL rstdwell_async: got %b want %b", d_vec(), 11'b0001_0000_000);
    end
    model_reset();
    #1 reset = 1'b0;
    tick();
    n_vec++;
    if (d_vec() !== m_vec()) begin
      n_err++; $display("FAIL rstdwell_after: dut=%b model=%b", d_vec(), m_vec());
    end
  endtask

  task automatic test_intermediate();
    travel_to(0);
    call_btn = 4'b1000;
    tick();
    call_btn = '0;
    for (int c = 0; c < 50 && pos != 1; c++) tick();
    call_btn = 4'b0100;
    tick();
    call_btn = '0;
    n_vec++;
    if (pending !== 4'b1100) begin
      n_err++; $display("FAIL pickup_latch: got %b want %b", pending, 4'b1100);
    end
    tick();
    n_vec++;
    if (requested_floor !== 4'b0100) begin
      n_err++; $display("FAIL pickup_retarget: got %b want %b", requested_floor, 4'b0100);
    end
    for (int c = 0; c < 100 && !m_door; c++) begin
      tick();
      n_vec++;
      if (d_vec() !== m_vec()) begin
        n_err++; $display("FAIL pickup_move: dut=%b model=%b", d_vec(), m_vec());
      end
    end
    n_vec++;
    if ({door_open, present_floor} !== {1'b1, 4'b0100}) begin
      n_err++; $display("FAIL pickup_stop2: got %b want %b", {door_open, present_floor}, 5'b10100);
    end
    for (int c = 0; c < 100 && !(m_door && pos == 3); c++) tick();
    n_vec++;
    if ({door_open, present_floor, pending} !== {1'b1, 4'b1000, 4'b0000}) begin
      n_err++; $display("FAIL pickup_stop3: got %b want %b",
                        {door_open, present_floor, pending}, 9'b110000000);
    end
  endtask

  task automatic test_direction();
    travel_to(0);
    call_btn = 4'b1010;
    tick();
    call_btn = '0;
    for (int c = 0; c < 100 && !m_door; c++) tick();
    n_vec++;
    if ({present_floor, pending} !== {4'b0010, 4'b1000}) begin
      n_err++; $display("FAIL dir_stop1: got %b want %b", {present_floor, pending}, 8'b00101000);
    end
    call_btn = 4'b0001;
    tick();
    call_btn = '0;
    n_vec++;
    if (pending !== 4'b1001) begin
      n_err++; $display("FAIL dir_pend: got %b want %b", pending, 4'b1001);
    end
    for (int c = 0; c < 20 && m_door; c++) tick();
    n_vec++;
    if ({requested_floor, busy, door_open} !== {4'b1000, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL dir_keep_up: got %b want %b", {requested_floor, busy, door_open}, 6'b100010);
    end
    for (int c = 0; c < 100 && !m_door; c++) tick();
    for (int c = 0; c < 20 && m_door; c++) tick();
    n_vec++;
    if ({requested_floor, present_floor} !== {4'b0001, 4'b1000}) begin
      n_err++; $display("FAIL dir_reverse: got %b want %b", {requested_floor, present_floor}, 8'b00011000);
    end
    for (int c = 0; c < 100 && !(m_mode == M_IDLE && pos == 0); c++) begin
      tick();
      n_vec++;
      if (d_vec() !== m_vec()) begin
        n_err++; $display("FAIL dir_return: dut=%b model=%b", d_vec(), m_vec());
      end
    end
  endtask

  task automatic test_same_floor();
    int door_cnt;
    call_btn = 4'b0001;
    tick();
    call_btn = '0;
    n_vec++;
    if ({door_open, pending} !== {1'b1, 4'b0000}) begin
      n_err++; $display("FAIL same_direct: got %b want %b", {door_open, pending}, 5'b10000);
    end
    door_cnt = 1;
    tick();
    if (door_open) door_cnt++;
    call_btn = 4'b0001;
    tick();
    call_btn = '0;
    if (door_open) door_cnt++;
    for (int c = 0; c < 20 && door_open; c++) begin
      tick();
      if (door_open) door_cnt++;
      n_vec++;
      if (pending[0] !== 1'b0) begin
        n_err++; $display("FAIL same_absorb: got %b want %b", pending[0], 1'b0);
      end
    end
    n_vec++;
    if (door_cnt != 6) begin
      n_err++; $display("FAIL same_extend: got %0d want %0d", door_cnt, 6);
    end
  endtask

  task automatic test_fault();
    call_btn = 4'b1000;
    tick();
    call_btn = '0;
    for (int c = 0; c < 50 && pos != 1; c++) tick();
    fault_inj = 1'b1;
    present_floor = 4'b0000;
    call_btn = 4'b0100;
    tick();
    call_btn = '0;
    n_vec++;
    if (d_vec() !== {4'b0001, 4'b1100, 1'b0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL fault_enter: got %b want %b", d_vec(), 11'b0001_1100_001);
    end
    repeat (3) begin
      tick();
      n_vec++;
      if (d_vec() !== m_vec()) begin
        n_err++; $display("FAIL fault_hold: dut=%b model=%b", d_vec(), m_vec());
      end
    end
    fault_inj = 1'b0;
    present_floor = 4'b0010;
    tick();
    n_vec++;
    if ({fault, requested_floor} !== {1'b0, 4'b0100}) begin
      n_err++; $display("FAIL fault_resume: got %b want %b", {fault, requested_floor}, 5'b00100);
    end
    for (int c = 0; c < 200 && !(m_mode == M_IDLE && m_pend == '0); c++) begin
      tick();
      n_vec++;
      if (d_vec() !== m_vec()) begin
        n_err++; $display("FAIL fault_service: dut=%b model=%b", d_vec(), m_vec());
      end
    end
    n_vec++;
    if ({pending, busy} !== 5'b00000) begin
      n_err++; $display("FAIL fault_drain: got %b want %b", {pending, busy}, 5'b00000);
    end
  endtask

  task automatic test_random();
    int fault_left;
    logic [N-1:0] bad;
    fault_left = 0;
    for (int c = 0; c < 3000; c++) begin
      call_btn = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      if (fault_left > 0) begin
        fault_left--;
        if (fault_left == 0) begin
          fault_inj = 1'b0;
          present_floor = N'(1) << pos;
        end
      end else if ($urandom_range(0, 249) == 0) begin
        fault_left = $urandom_range(1, 5);
        fault_inj = 1'b1;
        case ($urandom_range(0, 2))
          0: bad = 4'b0000;
          1: bad = 4'b0011;
          default: bad = 4'b1111;
        endcase
        present_floor = bad;
      end
      tick();
      n_vec++;
      if (d_vec() !== m_vec()) begin
        n_err++; $display("FAIL random c=%0d: dut=%b model=%b", c, d_vec(), m_vec());
      end
    end
    call_btn = '0;
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_reset_mid_dwell();
    test_intermediate();
    test_direction();
    test_same_floor();
    test_fault();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
